// File: rtl/config_mux_if.sv
// config_mux_if: bundles the data and serial configuration signals of one
// config_mux instance. The clock and reset are not part of it.
//   data_in        candidate inputs (WIDTH bits)
//   data_en        output register enable (registered mode)
//   config_enable  shift the config chain this cycle
//   config_in      serial config bit from the previous instance
//   config_out     serial config bit to the next instance
//   config_loaded  high once a full configuration has been shifted in
//   data_out       selected input
// master: the side that drives the mux (fabric / bench).
// slave:  the mux itself.
interface config_mux_if #(
  parameter int WIDTH = 44
);
  logic [WIDTH-1:0] data_in;
  logic             data_en;
  logic             config_enable;
  logic             config_in;
  logic             config_out;
  logic             config_loaded;
  logic             data_out;

  modport master (
    output data_in, data_en, config_enable, config_in,
    input  config_out, config_loaded, data_out
  );

  modport slave (
    input  data_in, data_en, config_enable, config_in,
    output config_out, config_loaded, data_out
  );
endinterface

// File: rtl/config_mux.sv
// config_mux: self-configuring WIDTH:1 routing mux for the kfpga interconnect.
// The select code and the output mode live in a serial config shift register
// that daisy-chains through config_in/config_out (sent LSB first).
//   clock  single clock, rising edge
//   reset  asynchronous, active-high
//   bus    config_mux_if.slave (data_in, data_en, config_enable, config_in,
//          config_out, config_loaded, data_out)
// Config layout: cfg[SEL_W-1:0] = select code, cfg[SEL_W] = mode
// (0 combinational, 1 registered). data_out stays 0 until a full config has
// been loaded and whenever the chain is shifting.
module config_mux #(
  parameter int WIDTH = 44
) (
  input logic        clock,
  input logic        reset,
  config_mux_if.slave bus
);

  localparam int SEL_W = $clog2(WIDTH);
  localparam int CFG_W = SEL_W + 1;
  localparam int CNT_W = $clog2(CFG_W + 1);
  localparam int PAD_W = 2 ** SEL_W;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CFG_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_W - 1);

  logic [CFG_W-1:0] cfg;
  logic [CNT_W-1:0] shift_cnt;
  logic             loaded;
  logic             out_q;

  logic [SEL_W-1:0] sel_code;
  logic             mode;
  logic [PAD_W-1:0] tree;
  logic             sel_bit;

  assign sel_code = cfg[SEL_W-1:0];
  assign mode     = cfg[SEL_W];

  // Config chain and load tracking. The counter saturates so that extra
  // shifts simply pass bits on to downstream instances.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cfg       <= '0;
      shift_cnt <= '0;
      loaded    <= 1'b0;
    end else if (bus.config_enable) begin
      cfg <= {bus.config_in, cfg[CFG_W-1:1]};
      if (shift_cnt != CNT_FULL) begin
        shift_cnt <= shift_cnt + 1'b1;
      end
      if (shift_cnt == CNT_LAST) begin
        loaded <= 1'b1;
      end
    end
  end

  // Reduction tree over the zero-padded inputs. Each level halves the
  // candidate set using one select bit, MSB first; padded slots are 0, so
  // out-of-range codes yield 0.
  always_comb begin
    tree = '0;
    tree[WIDTH-1:0] = bus.data_in;
    for (int lvl = SEL_W - 1; lvl >= 0; lvl--) begin
      for (int i = 0; i < (1 << lvl); i++) begin
        tree[i] = sel_code[lvl] ? tree[i + (1 << lvl)] : tree[i];
      end
    end
    sel_bit = tree[0];
  end

  // Keeps tracking during config shifts; masking happens at the output only.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_q <= 1'b0;
    end else if (bus.data_en) begin
      out_q <= sel_bit;
    end
  end

  assign bus.config_out    = cfg[0];
  assign bus.config_loaded = loaded;
  assign bus.data_out      = (loaded && !bus.config_enable) ?
                             (mode ? out_q : sel_bit) : 1'b0;

endmodule

// File: tb/tb_config_mux.sv
module tb_config_mux;

  localparam int W = 44;

  logic clock = 1'b0;
  logic reset;

  int total = 0;
  int bad   = 0;

  config_mux_if #(.WIDTH(W)) b0 ();
  config_mux_if #(.WIDTH(W)) b1 ();

  config_mux #(.WIDTH(W)) u0 (.clock(clock), .reset(reset), .bus(b0));
  config_mux #(.WIDTH(W)) u1 (.clock(clock), .reset(reset), .bus(b1));

  // u1 sits downstream of u0 on the config chain.
  assign b1.config_in     = b0.config_out;
  assign b1.config_enable = b0.config_enable;

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Shift n bits of val LSB first; leaves config_enable high.
  task automatic shift_in(input logic [13:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      b0.config_in     = val[i];
      b0.config_enable = 1'b1;
      step();
    end
  endtask

  logic [13:0] stream;
  logic        prev;
  logic [3:0]  seq;

  initial begin
    reset            = 1'b1;
    b0.data_in       = '1;
    b0.data_en       = 1'b0;
    b0.config_enable = 1'b0;
    b0.config_in     = 1'b0;
    b1.data_in       = '0;
    b1.data_en       = 1'b0;
    #1;
    chk("rst_data_out", b0.data_out, 1'b0);
    chk("rst_loaded", b0.config_loaded, 1'b0);
    chk("rst_config_out", b0.config_out, 1'b0);
    step();
    step();
    reset = 1'b0;
    #1;
    chk("post_rst_data_out", b0.data_out, 1'b0);

    // select 37, mode 0: stream 1,0,1,0,0,1,0
    b0.data_in = '0;
    b0.data_in[37] = 1'b1;
    shift_in(14'b0100101, 6);
    chk("loaded_after_6", b0.config_loaded, 1'b0);
    shift_in(14'b0100101 >> 6, 1);
    chk("loaded_after_7", b0.config_loaded, 1'b1);
    chk("masked_during_shift", b0.data_out, 1'b0);
    b0.config_enable = 1'b0;
    #1;
    chk("sel37_out", b0.data_out, 1'b1);
    b0.data_in = '0;
    #1;
    chk("sel37_zero", b0.data_out, 1'b0);
    b0.data_in = '1;
    b0.data_in[37] = 1'b0;
    #1;
    chk("sel37_others_high", b0.data_out, 1'b0);

    // select 50 (out of range), mode 0
    shift_in(14'b0110010, 7);
    b0.config_enable = 1'b0;
    b0.data_in = '1;
    #1;
    chk("sel50_out", b0.data_out, 1'b0);

    // select 43 (last valid input), mode 0
    shift_in(14'b0101011, 7);
    b0.config_enable = 1'b0;
    b0.data_in = '0;
    b0.data_in[43] = 1'b1;
    #1;
    chk("sel43_out", b0.data_out, 1'b1);

    // select 5, mode 1
    b0.data_in = '0;
    b0.data_en = 1'b1;
    shift_in(14'b1000101, 7);
    b0.config_enable = 1'b0;
    #1;
    chk("sel5_start", b0.data_out, 1'b0);
    seq  = 4'b0110;
    prev = 1'b0;
    for (int k = 0; k < 4; k++) begin
      b0.data_in = '0;
      b0.data_in[5] = seq[3-k];
      #1;
      chk("reg_before_edge", b0.data_out, prev);
      step();
      chk("reg_after_edge", b0.data_out, seq[3-k]);
      prev = seq[3-k];
    end
    b0.data_in[5] = 1'b1;
    step();
    chk("reg_load_one", b0.data_out, 1'b1);
    b0.data_en = 1'b0;
    b0.data_in = '0;
    step();
    chk("reg_hold_1", b0.data_out, 1'b1);
    step();
    chk("reg_hold_2", b0.data_out, 1'b1);
    b0.config_enable = 1'b1;
    #1;
    chk("reg_masked_by_enable", b0.data_out, 1'b0);
    b0.config_enable = 1'b0;
    #1;
    chk("reg_unmasked", b0.data_out, 1'b1);

    // chain: first 7 bits (select 5, mode 0) land in u1, last 7 (select 3) in u0
    stream = {7'b0000011, 7'b0000101};
    for (int k = 0; k < 14; k++) begin
      b0.config_in     = stream[k];
      b0.config_enable = 1'b1;
      step();
      if (k >= 6) chk("chain_config_out", b0.config_out, stream[k-6]);
    end
    b0.config_enable = 1'b0;
    b0.data_in = '0;
    b0.data_in[3] = 1'b1;
    b1.data_in = '0;
    b1.data_in[5] = 1'b1;
    #1;
    chk("chain_u0_sel3", b0.data_out, 1'b1);
    chk("chain_u1_sel5", b1.data_out, 1'b1);
    chk("chain_u1_loaded", b1.config_loaded, 1'b1);
    b1.data_in = '0;
    b1.data_in[3] = 1'b1;
    #1;
    chk("chain_u1_not_sel3", b1.data_out, 1'b0);

    // reset mid-load: select 20 partial, then full reload of select 10
    reset = 1'b1;
    step();
    reset = 1'b0;
    shift_in(14'b0010100, 3);
    chk("partial_loaded", b0.config_loaded, 1'b0);
    reset = 1'b1;
    #1;
    chk("rst_with_enable_cfg_out", b0.config_out, 1'b0);
    step();
    chk("rst_with_enable_loaded", b0.config_loaded, 1'b0);
    reset = 1'b0;
    shift_in(14'b0010100 >> 3, 4);
    chk("after_rst_4_shifts", b0.config_loaded, 1'b0);
    shift_in(14'b0001010, 7);
    chk("reload_loaded", b0.config_loaded, 1'b1);
    b0.config_enable = 1'b0;
    b0.data_in = '0;
    b0.data_in[10] = 1'b1;
    #1;
    chk("reload_sel10", b0.data_out, 1'b1);
    b0.data_in = '0;
    b0.data_in[20] = 1'b1;
    #1;
    chk("reload_not_sel20", b0.data_out, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
